// File: rtl/eth_mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO management master.
// The frame builder keeps the bit layout in one place for the controller.
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        TA,
        DATA
    } mdio_state_t;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int MDIO_PRE_BITS   = 32;
    localparam int MDIO_HDR_BITS   = 14;
    localparam int MDIO_TA_BITS    = 2;
    localparam int MDIO_FRAME_BITS = 64;
    localparam int MDIO_TA_FIRST   = MDIO_PRE_BITS + MDIO_HDR_BITS;
    localparam int MDIO_DATA_FIRST = MDIO_TA_FIRST + MDIO_TA_BITS;

    // Frame bit 0 lands in [63] so the line is always driven from the MSB.
    // Read frames fill TA/data with ones; those bits are never driven anyway.
    function automatic logic [MDIO_FRAME_BITS-1:0] mdio_frame(
        input logic        rd,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        return {{MDIO_PRE_BITS{1'b1}}, MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR),
                phyad, regad, (rd ? 2'b11 : MDIO_TA_WR), (rd ? 16'hFFFF : wdata)};
    endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC half-period divider: each bit is CLK_DIV low cycles then CLK_DIV high cycles.
// Emits single-cycle enables at the end of each phase; restarted at frame accept.
module mdio_clk_div #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic en_i,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sample_tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          high_q, high_d;
    logic          last;

    assign last = (cnt_q == CW'(CLK_DIV - 1));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cnt_d  = cnt_q;
        high_d = high_q;
        if (clear_i) begin
            cnt_d  = '0;
            high_d = 1'b0;
        end else if (en_i) begin
            if (last) begin
                cnt_d  = '0;
                high_d = ~high_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            high_q <= high_d;
        end
    end

    assign rise_tick_o   = en_i & ~high_q & last;
    assign fall_tick_o   = en_i &  high_q & last;
    assign sample_tick_o = en_i &  high_q & last;

endmodule

// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO master: one 64-bit read or write frame per accepted command.
// FSM, frame shift register and MDIO input synchronizer live here.
module eth_mdio_ctrl
    import eth_mdio_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic        i_read,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_mdc,
    output logic        o_mdio_o,
    output logic        o_mdio_oe,
    input  logic        i_mdio_i
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("eth_mdio_ctrl: CLK_DIV must be >= 2");
    end

    mdio_state_t state_q, state_d;

    logic [5:0]                 bit_cnt_q;
    logic [MDIO_FRAME_BITS-1:0] tx_q;
    logic [15:0]                rx_q;
    logic [15:0]                rdata_q;
    logic [1:0]                 sync_q;
    logic                       mdc_q, oe_q, done_q, rd_q;
    logic                       busy, accept, rise, fall, sample, last_bit;

    assign busy     = (state_q != IDLE);
    assign accept   = i_start & ~busy;
    assign last_bit = (bit_cnt_q == 6'(MDIO_FRAME_BITS - 1));

    mdio_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk          (clk),
        .rstn         (rstn),
        .clear_i      (accept),
        .en_i         (busy),
        .rise_tick_o  (rise),
        .fall_tick_o  (fall),
        .sample_tick_o(sample)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = PREAMBLE;
            PREAMBLE: if (fall && bit_cnt_q == 6'(MDIO_PRE_BITS - 1))   state_d = HEADER;
            HEADER:   if (fall && bit_cnt_q == 6'(MDIO_TA_FIRST - 1))   state_d = TA;
            TA:       if (fall && bit_cnt_q == 6'(MDIO_DATA_FIRST - 1)) state_d = DATA;
            DATA:     if (fall && last_bit)                             state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The line idles high because tx_q refills with ones; bit 63 is the live bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q <= '0;
            tx_q      <= '1;
            rx_q      <= '0;
            rdata_q   <= '0;
            sync_q    <= '0;
            mdc_q     <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_mdio_i};
            done_q <= 1'b0;
            if (accept) begin
                tx_q      <= mdio_frame(i_read, i_phy_addr, i_reg_addr, i_wdata);
                rd_q      <= i_read;
                oe_q      <= 1'b1;
                mdc_q     <= 1'b0;
                bit_cnt_q <= '0;
                rx_q      <= '0;
            end else if (busy) begin
                if (rise) mdc_q <= 1'b1;
                if (sample && rd_q && bit_cnt_q >= 6'(MDIO_DATA_FIRST))
                    rx_q <= {rx_q[14:0], sync_q[1]};
                if (fall) begin
                    mdc_q     <= 1'b0;
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                    if (last_bit) begin
                        tx_q   <= '1;
                        oe_q   <= 1'b0;
                        done_q <= 1'b1;
                        if (rd_q) rdata_q <= {rx_q[14:0], sync_q[1]};
                    end else begin
                        tx_q <= {tx_q[MDIO_FRAME_BITS-2:0], 1'b1};
                        if (rd_q && bit_cnt_q == 6'(MDIO_TA_FIRST - 1)) oe_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_rdata   = rdata_q;
    assign o_busy    = busy;
    assign o_done    = done_q;
    assign o_mdc     = mdc_q;
    assign o_mdio_o  = tx_q[MDIO_FRAME_BITS-1];
    assign o_mdio_oe = oe_q;

endmodule
